ni_tx: RTL and testbench

NI_TX -- requirements
Module: ni_tx

---
 rtl/ni_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ni_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ni_tx
// Brief    : Clocked packet injector for one asynchronous 4-phase
//            bundled-data link (req/Data/ack/Tailpassed/PacketEnable).
//            Local flits are buffered in a small circular FIFO, then issued
//            one at a time with a full clock of data setup before req rises.
// Revision : 1.0 - initial release
// ============================================================================
module ni_tx #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wr_last_i,
    output logic             wr_ready_o,
    output logic             req_o,
    output logic [WIDTH-1:0] Data_o,
    input  logic             ack_i,
    input  logic             Tailpassed_i,
    output logic             PacketEnable_o,
    output logic             busy_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        REQ_HI    = 3'd2,
        REQ_LO    = 3'd3,
        WAIT_TAIL = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // FIFO storage: each entry is {last, data}
    logic [WIDTH:0]          r_mem [DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_CW-1:0]         r_count;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_empty;
    logic [WIDTH:0]          w_head;

    // Synchronizers for the asynchronous link inputs
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic [SYNC_STAGES-1:0]  r_tail_sync;
    logic                    w_ack_s;
    logic                    w_tail_s;
    logic                    r_tail_s_d;
    logic                    w_tail_rise;

    logic                    r_last;
    logic                    r_tail_seen;
    logic                    w_req_nxt;
    logic                    w_pe_nxt;
    logic                    w_tail_clr;

    assign wr_ready_o  = (r_count != c_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = wr_valid_i & wr_ready_o;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign w_tail_s    = r_tail_sync[SYNC_STAGES-1];
    assign w_tail_rise = w_tail_s & ~r_tail_s_d;
    assign busy_o      = (r_state != IDLE) || !w_empty;

    // FIFO storage write; contents are don't-care while the count is zero
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_last_i, wr_data_i};
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Multi-flop synchronizers plus edge history for tail detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_sync  <= '0;
            r_tail_sync <= '0;
            r_tail_s_d  <= 1'b0;
        end else begin
            r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], ack_i};
            r_tail_sync <= {r_tail_sync[SYNC_STAGES-2:0], Tailpassed_i};
            r_tail_s_d  <= w_tail_s;
        end
    end

    // Handshake state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode for the 4-phase handshake
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_req_nxt   = req_o;
        w_pe_nxt    = PacketEnable_o;
        w_tail_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                // A stale ack still high from the link blocks the next issue
                if (!w_empty && !w_ack_s) begin
                    w_pop       = 1'b1;
                    w_pe_nxt    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_req_nxt   = 1'b1;
                w_state_nxt = REQ_HI;
            end
            REQ_HI: begin
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_state_nxt = r_last ? WAIT_TAIL : IDLE;
                end
            end
            WAIT_TAIL: begin
                if (r_tail_seen) begin
                    w_pe_nxt    = 1'b0;
                    w_tail_clr  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered link outputs; Data_o only moves on a pop in IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_o          <= 1'b0;
            PacketEnable_o <= 1'b0;
            Data_o         <= '0;
            r_last         <= 1'b0;
        end else begin
            req_o          <= w_req_nxt;
            PacketEnable_o <= w_pe_nxt;
            if (w_pop) begin
                Data_o <= w_head[WIDTH-1:0];
                r_last <= w_head[WIDTH];
            end
        end
    end

    // Tail capture: an early tail edge (during the tail flit's handshake)
    // is held until WAIT_TAIL consumes it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tail_seen <= 1'b0;
        end else if (w_tail_clr) begin
            r_tail_seen <= 1'b0;
        end else if (w_tail_rise && PacketEnable_o && r_last) begin
            r_tail_seen <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ni_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ni_tx
// Brief    : Self-checking bench for ni_tx: vector table of single flits,
//            directed multi-cycle corner cases, and a randomized run scored
//            against an in-order flit queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ni_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic        req;
    logic [31:0] data_o;
    logic        ack = 1'b0;
    logic        tail = 1'b0;
    logic        pe;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          ack_dly;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_pe_end;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } flit_t;

    vec_t  vecs[6];
    flit_t exp_q[$];

    ni_tx #(
        .WIDTH      (32),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .wr_last_i     (wr_last),
        .wr_ready_o    (wr_ready),
        .req_o         (req),
        .Data_o        (data_o),
        .ack_i         (ack),
        .Tailpassed_i  (tail),
        .PacketEnable_o(pe),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event-missing required=event", name);
    endtask

    // advance n rising edges, then step off the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic lvl, input string name);
        int n = 0;
        while (req !== lvl && n < 300) begin
            tick(1);
            n++;
        end
        check(name, req, lvl);
    endtask

    task automatic wait_pe_low(input string name);
        int n = 0;
        while (pe !== 1'b0 && n < 30) begin
            tick(1);
            n++;
        end
        check(name, pe, 1'b0);
    endtask

    // one 4-phase handshake acting as the link
    task automatic do_hs(input int dly, input logic [31:0] exp_d, input string tag);
        wait_req(1'b1, {tag, "_req_rise"});
        check({tag, "_data"}, data_o, exp_d);
        check({tag, "_pe_open"}, pe, 1'b1);
        tick(dly);
        ack = 1'b1;
        wait_req(1'b0, {tag, "_req_fall"});
        check({tag, "_data_stable"}, data_o, exp_d);
        tick(dly);
        ack = 1'b0;
    endtask

    task automatic close_pkt(input int dly, input string tag);
        tick(dly);
        check({tag, "_pe_before_tail"}, pe, 1'b1);
        tail = 1'b1;
        tick(2);
        tail = 1'b0;
        wait_pe_low({tag, "_pe_drop"});
    endtask

    task automatic push_one(input logic [31:0] d, input logic l, input string tag);
        wr_data  = d;
        wr_last  = l;
        wr_valid = 1'b1;
        check({tag, "_ready"}, wr_ready, 1'b1);
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        push_one(v.data, v.last, "vec");
        check("vec_req_T0", req, 1'b0);
        tick(1);
        n = 1;
        check("vec_data_T1", data_o, v.exp_data);
        check("vec_req_T1", req, 1'b0);
        while (req !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check("vec_req_latency", n, v.exp_lat);
        do_hs(v.ack_dly, v.exp_data, "vec_hs");
        if (v.last) close_pkt(3, "vec");
        else tick(5);
        check("vec_pe_end", pe, v.exp_pe_end);
        check("vec_busy_end", busy, 1'b0);
        check("vec_req_end", req, 1'b0);
    endtask

    task automatic random_test();
        flit_t gen[$];
        int    nf;
        for (int p = 0; p < 8; p++) begin
            int len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                flit_t f;
                f.data = $urandom;
                f.last = (i == len - 1);
                gen.push_back(f);
            end
        end
        nf = gen.size();
        fork
            begin : producer
                for (int i = 0; i < nf; i++) begin
                    int n = 0;
                    tick($urandom_range(0, 2));
                    wr_data  = gen[i].data;
                    wr_last  = gen[i].last;
                    wr_valid = 1'b1;
                    while (wr_ready !== 1'b1 && n < 500) begin
                        tick(1);
                        n++;
                    end
                    check("rnd_accept", wr_ready, 1'b1);
                    tick(1);
                    exp_q.push_back(gen[i]);
                    wr_valid = 1'b0;
                end
            end
            begin : link
                for (int i = 0; i < nf; i++) begin
                    flit_t e;
                    int    d;
                    wait_req(1'b1, "rnd_req_rise");
                    if (req !== 1'b1) break;
                    if (exp_q.size() == 0) begin
                        fail("rnd_unexpected_flit");
                        break;
                    end
                    e = exp_q.pop_front();
                    check("rnd_data", data_o, e.data);
                    check("rnd_pe_open", pe, 1'b1);
                    d = $urandom_range(0, 3);
                    tick(d);
                    ack = 1'b1;
                    wait_req(1'b0, "rnd_req_fall");
                    check("rnd_data_stable", data_o, e.data);
                    tick($urandom_range(0, 3));
                    ack = 1'b0;
                    if (e.last) close_pkt($urandom_range(2, 6), "rnd");
                end
            end
        join
        tick(10);
        check("rnd_queue_drained", exp_q.size(), 0);
        check("rnd_busy_end", busy, 1'b0);
    endtask

    initial begin
        logic exp_rdy[6];
        int   seen;
        int   n;

        vecs[0] = '{32'hA5A5A5A5, 1'b1, 3, 2, 32'hA5A5A5A5, 1'b0};
        vecs[1] = '{32'h00000001, 1'b0, 1, 2, 32'h00000001, 1'b1};
        vecs[2] = '{32'h00000002, 1'b0, 2, 2, 32'h00000002, 1'b1};
        vecs[3] = '{32'h00000003, 1'b1, 0, 2, 32'h00000003, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 1'b1, 2, 2, 32'hFFFFFFFF, 1'b0};
        vecs[5] = '{32'h00000000, 1'b1, 1, 2, 32'h00000000, 1'b0};

        // reset state
        rst = 1'b1;
        tick(2);
        check("rst_req", req, 1'b0);
        check("rst_data", data_o, 32'h0);
        check("rst_pe", pe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", wr_ready, 1'b1);
        rst = 1'b0;
        tick(1);

        // table of single-flit issues, including a 3-flit packet
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // fill the FIFO with the link stalled
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
        exp_rdy[3] = 1'b1; exp_rdy[4] = 1'b1; exp_rdy[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_data  = 32'h10 + i;
            wr_last  = (i >= 4);
            wr_valid = 1'b1;
            check("full_ready", wr_ready, exp_rdy[i]);
            tick(1);
        end
        wr_valid = 1'b0;
        tick(3);
        check("full_ready_hold", wr_ready, 1'b0);
        check("full_req_held", req, 1'b1);
        check("full_head", data_o, 32'h10);
        for (int i = 0; i < 5; i++) do_hs(1, 32'h10 + i, "full_hs");
        close_pkt(3, "full");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (req === 1'b1) seen++;
        end
        check("full_no_extra_flit", seen, 0);
        check("full_busy_end", busy, 1'b0);

        // tail edge arriving while the tail flit is still in REQ_LO
        push_one(32'h5A5A0001, 1'b1, "early");
        wait_req(1'b1, "early_req_rise");
        ack = 1'b1;
        wait_req(1'b0, "early_req_fall");
        tail = 1'b1;
        tick(2);
        tail = 1'b0;
        tick(2);
        check("early_pe_hold", pe, 1'b1);
        ack = 1'b0;
        n = 0;
        while (pe !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        check("early_tail_exit_cycles", n, 4);

        // reset in the middle of a handshake with flits queued
        push_one(32'h20, 1'b0, "mid");
        push_one(32'h21, 1'b0, "mid");
        push_one(32'h22, 1'b1, "mid");
        wait_req(1'b1, "mid_req_rise");
        tick(1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_pe", pe, 1'b0);
        check("mid_rst_data", data_o, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", wr_ready, 1'b1);
        tick(1);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (req === 1'b1) seen++;
        end
        check("mid_no_reissue", seen, 0);
        check("mid_busy_after", busy, 1'b0);

        // ack stuck high across reset release
        ack = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        push_one(32'h77, 1'b1, "stale");
        tick(10);
        check("stale_req_blocked", req, 1'b0);
        check("stale_busy", busy, 1'b1);
        ack = 1'b0;
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check("stale_issue_latency", n, 4);
        do_hs(1, 32'h77, "stale_hs");
        close_pkt(3, "stale");

        // randomized traffic against the queue model
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        random_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
